// File: rtl/aer_output_encoder_if.sv
// Four-phase AER link: the encoder drives request, address and timestamp,
// and the receiver returns the acknowledge.
interface aer_output_encoder_if #(
  parameter int TS_WIDTH = 16
);
  logic                aer_req;
  logic                aer_ack;
  logic [1:0]          aer_addr;
  logic [TS_WIDTH-1:0] aer_ts;

  modport master (output aer_req, output aer_addr, output aer_ts, input aer_ack);
  modport slave  (input aer_req, input aer_addr, input aer_ts, output aer_ack);
endinterface

// File: rtl/aer_output_encoder.sv
// Timestamps spikes from three output neurons, arbitrates them round-robin
// into an event FIFO and sends each event over a four-phase AER handshake.
module aer_output_encoder #(
  parameter int  FIFO_DEPTH = 8,
  parameter int  TS_WIDTH   = 16,
  localparam int AW         = $clog2(FIFO_DEPTH)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  enable,
  input  logic [2:0]            spike_in,
  aer_output_encoder_if.master  aer,
  output logic [AW:0]           fifo_count,
  output logic [7:0]            drop_count,
  output logic                  busy
);

  typedef enum logic [1:0] {IDLE, REQ, ACK_LOW} state_t;

  state_t              state_reg, state_next;
  logic [TS_WIDTH-1:0] ts_cnt;
  logic [2:0]          pending;
  logic [TS_WIDTH-1:0] ts_lat [3];
  logic [1:0]          rr_ptr;
  logic [2:0]          grant;
  logic [1:0]          grant_idx;
  logic                grant_valid;
  logic [2:0]          cand;
  logic [2:0]          capture;
  logic [2:0]          drop;
  logic [8:0]          drop_sum;
  logic                fifo_full, fifo_empty, pop;
  logic [AW-1:0]       wr_ptr, rd_ptr;
  logic [TS_WIDTH+1:0] mem [FIFO_DEPTH];
  logic [1:0]          addr_reg;
  logic [TS_WIDTH-1:0] ts_reg;

  assign fifo_full  = (fifo_count == (AW+1)'(FIFO_DEPTH));
  assign fifo_empty = (fifo_count == '0);

  // Round-robin search starts at rr_ptr, which points just past the last grant.
  always_comb begin
    grant_valid = 1'b0;
    grant_idx   = 2'd0;
    cand        = 3'd0;
    if (!fifo_full) begin
      for (int k = 0; k < 3; k++) begin
        cand = {1'b0, rr_ptr} + 3'(k);
        if (cand >= 3'd3) cand = cand - 3'd3;
        if (!grant_valid && pending[cand[1:0]]) begin
          grant_valid = 1'b1;
          grant_idx   = cand[1:0];
        end
      end
    end
    grant = grant_valid ? (3'b001 << grant_idx) : 3'b000;
  end

  // A spike on a neuron being granted this cycle re-arms its latch instead of dropping.
  for (genvar gi = 0; gi < 3; gi++) begin : g_neuron
    assign capture[gi] = enable & spike_in[gi] & (~pending[gi] | grant[gi]);
    assign drop[gi]    = enable & spike_in[gi] & pending[gi] & ~grant[gi];

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        pending[gi] <= 1'b0;
        ts_lat[gi]  <= '0;
      end else if (capture[gi]) begin
        pending[gi] <= 1'b1;
        ts_lat[gi]  <= ts_cnt;
      end else if (grant[gi]) begin
        pending[gi] <= 1'b0;
      end
    end
  end

  assign drop_sum = {1'b0, drop_count} + 9'(drop[0]) + 9'(drop[1]) + 9'(drop[2]);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ts_cnt     <= '0;
      drop_count <= '0;
      rr_ptr     <= 2'd0;
    end else begin
      if (enable) ts_cnt <= ts_cnt + TS_WIDTH'(1);
      drop_count <= drop_sum[8] ? 8'hFF : drop_sum[7:0];
      if (grant_valid) rr_ptr <= (grant_idx == 2'd2) ? 2'd0 : grant_idx + 2'd1;
    end
  end

  // Storage carries no reset so it maps onto RAM; only pointers are cleared.
  always_ff @(posedge clk) begin
    if (grant_valid) mem[wr_ptr] <= {grant_idx, ts_lat[grant_idx]};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_count <= '0;
    end else begin
      if (grant_valid) wr_ptr <= wr_ptr + AW'(1);
      if (pop)         rd_ptr <= rd_ptr + AW'(1);
      case ({grant_valid, pop})
        2'b10:   fifo_count <= fifo_count + (AW+1)'(1);
        2'b01:   fifo_count <= fifo_count - (AW+1)'(1);
        default: fifo_count <= fifo_count;
      endcase
    end
  end

  always_comb begin
    state_next = state_reg;
    pop        = 1'b0;
    case (state_reg)
      IDLE: begin
        if (!fifo_empty && !aer.aer_ack) begin
          pop        = 1'b1;
          state_next = REQ;
        end
      end
      REQ:     if (aer.aer_ack)  state_next = ACK_LOW;
      ACK_LOW: if (!aer.aer_ack) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg <= IDLE;
      addr_reg  <= 2'd0;
      ts_reg    <= '0;
    end else begin
      state_reg <= state_next;
      if (pop) {addr_reg, ts_reg} <= mem[rd_ptr];
    end
  end

  assign aer.aer_req  = (state_reg == REQ);
  assign aer.aer_addr = addr_reg;
  assign aer.aer_ts   = ts_reg;
  assign busy = (|pending) | ~fifo_empty | (state_reg != IDLE);

endmodule

// File: tb/tb_aer_output_encoder.sv
// Directed bench: stimulus queues expected AER events, a monitor pops and
// compares them on every rising aer_req.
module tb_aer_output_encoder;
  localparam int TS_W = 4;

  typedef struct packed {
    logic [1:0]      addr;
    logic [TS_W-1:0] ts;
  } evt_t;

  logic            clk = 1'b0;
  logic            rst_n;
  logic            enable;
  logic [2:0]      spike_in;
  logic [3:0]      fifo_count;
  logic [7:0]      drop_count;
  logic            busy;
  logic            ack_stop;
  logic [TS_W-1:0] ts_model;
  evt_t            exp_q[$];
  int              checks = 0;
  int              errors = 0;
  int              n_events = 0;

  aer_output_encoder_if #(.TS_WIDTH(TS_W)) aer_bus ();

  aer_output_encoder #(.FIFO_DEPTH(8), .TS_WIDTH(TS_W)) dut (
    .clk(clk), .rst_n(rst_n), .enable(enable), .spike_in(spike_in),
    .aer(aer_bus), .fifo_count(fifo_count), .drop_count(drop_count), .busy(busy)
  );

  always #5 clk = ~clk;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n)      ts_model <= '0;
    else if (enable) ts_model <= ts_model + 1'b1;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic push_exp(input logic [1:0] a, input logic [TS_W-1:0] t);
    evt_t e;
    e.addr = a;
    e.ts   = t;
    exp_q.push_back(e);
  endtask

  // Receiver: raises ack two cycles after seeing req, drops it once req falls.
  initial begin
    int age = 0;
    aer_bus.aer_ack = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      if (ack_stop) begin
        aer_bus.aer_ack = 1'b0;
        age = 0;
      end else if (!aer_bus.aer_ack && aer_bus.aer_req) begin
        if (age == 2) aer_bus.aer_ack = 1'b1;
        else age++;
      end else if (aer_bus.aer_ack && !aer_bus.aer_req) begin
        aer_bus.aer_ack = 1'b0;
        age = 0;
      end
    end
  end

  initial begin
    logic prev_req = 1'b0;
    evt_t e;
    forever begin
      @(negedge clk);
      if (aer_bus.aer_req && !prev_req) begin
        n_events++;
        $display("event %0d: addr=%0d ts=%0d", n_events, aer_bus.aer_addr, aer_bus.aer_ts);
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_event: got addr=%0d ts=%0d, expected none",
                   aer_bus.aer_addr, aer_bus.aer_ts);
        end else begin
          e = exp_q.pop_front();
          check("evt_addr", 32'(aer_bus.aer_addr), 32'(e.addr));
          check("evt_ts", 32'(aer_bus.aer_ts), 32'(e.ts));
        end
      end
      prev_req = aer_bus.aer_req;
    end
  end

  task automatic do_reset(input logic en);
    @(negedge clk);
    rst_n    = 1'b0;
    enable   = 1'b0;
    spike_in = 3'b000;
    exp_q.delete();
    repeat (2) @(negedge clk);
    enable = en;
    rst_n  = 1'b1;
  endtask

  task automatic wait_idle(input string name);
    int n = 0;
    while ((busy || aer_bus.aer_req || aer_bus.aer_ack || exp_q.size() != 0) && n < 300) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (n >= 300) begin
      errors++;
      $display("FAIL %s_timeout: got busy=%0d pending_events=%0d, expected idle", name, busy, exp_q.size());
    end
  endtask

  initial begin
    int base_events;
    logic [TS_W-1:0] base;
    logic [1:0] f_addr [7] = '{2'd0, 2'd2, 2'd0, 2'd2, 2'd0, 2'd2, 2'd0};
    int         f_off  [7] = '{0, 0, 1, 2, 3, 4, 5};

    rst_n = 1'b0; enable = 1'b0; spike_in = 3'b000; ack_stop = 1'b0;
    #12;
    check("rst_req", 32'(aer_bus.aer_req), 0);
    check("rst_addr", 32'(aer_bus.aer_addr), 0);
    check("rst_ts", 32'(aer_bus.aer_ts), 0);
    check("rst_busy", 32'(busy), 0);
    check("rst_fifo_count", 32'(fifo_count), 0);
    check("rst_drop_count", 32'(drop_count), 0);

    // Single spike on neuron 1 at edge 5
    do_reset(1'b1);
    base_events = n_events;
    repeat (5) @(posedge clk);
    #1 spike_in = 3'b010;
    push_exp(2'd1, 4'd5);
    @(posedge clk); #1 spike_in = 3'b000;
    @(posedge clk); #1 check("lat_req_edge6", 32'(aer_bus.aer_req), 0);
    @(posedge clk); #1;
    check("lat_req_edge7", 32'(aer_bus.aer_req), 1);
    check("lat_addr", 32'(aer_bus.aer_addr), 1);
    check("lat_ts", 32'(aer_bus.aer_ts), 5);
    wait_idle("single");
    check("single_events", 32'(n_events - base_events), 1);
    check("single_drops", 32'(drop_count), 0);

    // Three simultaneous spikes
    do_reset(1'b1);
    repeat (3) @(posedge clk);
    #1 spike_in = 3'b111;
    push_exp(2'd0, ts_model); push_exp(2'd1, ts_model); push_exp(2'd2, ts_model);
    @(posedge clk); #1 spike_in = 3'b000;
    wait_idle("simul");
    check("simul_drops", 32'(drop_count), 0);

    // Backpressure: receiver stalled, neuron 0 spikes for 20 cycles
    do_reset(1'b1);
    ack_stop = 1'b1;
    @(posedge clk); #1;
    for (int i = 0; i < 20; i++) begin
      spike_in = 3'b001;
      if (i < 10) push_exp(2'd0, ts_model);
      @(posedge clk); #1;
    end
    spike_in = 3'b000;
    check("bp_fifo_count", 32'(fifo_count), 8);
    check("bp_drop_count", 32'(drop_count), 10);
    check("bp_req_held", 32'(aer_bus.aer_req), 1);
    check("bp_busy", 32'(busy), 1);
    ack_stop = 1'b0;
    wait_idle("backpressure");
    check("bp_fifo_drained", 32'(fifo_count), 0);

    // Fairness between neurons 0 and 2
    do_reset(1'b1);
    @(posedge clk); #1;
    base = ts_model;
    for (int i = 0; i < 7; i++) push_exp(f_addr[i], base + TS_W'(f_off[i]));
    for (int i = 0; i < 6; i++) begin
      spike_in = 3'b101;
      @(posedge clk); #1;
    end
    spike_in = 3'b000;
    wait_idle("fair");
    check("fair_drops", 32'(drop_count), 5);

    // Timestamp wrap, then spikes ignored while disabled
    do_reset(1'b1);
    base_events = n_events;
    repeat (20) @(posedge clk);
    #1 spike_in = 3'b100;
    push_exp(2'd2, 4'd4);
    @(posedge clk); #1;
    enable = 1'b0; spike_in = 3'b111;
    repeat (5) @(posedge clk);
    #1 enable = 1'b1; spike_in = 3'b001;
    push_exp(2'd0, 4'd5);
    @(posedge clk); #1 spike_in = 3'b000;
    wait_idle("wrap");
    check("wrap_events", 32'(n_events - base_events), 2);
    check("wrap_drops", 32'(drop_count), 0);

    // Asynchronous reset in the REQ state with three events queued
    do_reset(1'b1);
    ack_stop = 1'b1;
    @(posedge clk); #1;
    spike_in = 3'b111;
    push_exp(2'd0, ts_model);
    @(posedge clk); #1 spike_in = 3'b001;
    @(posedge clk); #1 spike_in = 3'b000;
    repeat (4) @(posedge clk);
    #1;
    check("rq_fifo_count", 32'(fifo_count), 3);
    check("rq_req", 32'(aer_bus.aer_req), 1);
    base_events = n_events;
    rst_n = 1'b0;
    exp_q.delete();
    #1;
    check("rq_req_in_reset", 32'(aer_bus.aer_req), 0);
    check("rq_fifo_in_reset", 32'(fifo_count), 0);
    check("rq_busy_in_reset", 32'(busy), 0);
    repeat (2) @(negedge clk);
    ack_stop = 1'b0;
    rst_n = 1'b1;
    repeat (40) @(negedge clk);
    check("rq_no_events", 32'(n_events - base_events), 0);
    check("rq_busy_after", 32'(busy), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/aer_output_encoder.md
AER_OUTPUT_ENCODER -- requirements
Module: aer_output_encoder

Interface
REQ-001 The block SHALL take parameter FIFO_DEPTH, default 8, as the event FIFO depth, which SHALL be a power of 2 and at least 2.
REQ-002 The block SHALL take parameter TS_WIDTH, default 16, as the timestamp width in bits.
REQ-003 Port clk, input, 1 bit: clock; all state SHALL update on the rising edge.
REQ-004 Port rst_n, input, 1 bit: reset, asynchronous, active-low.
REQ-005 Port enable, input, 1 bit: when 1, spikes are captured and the timestamp counter runs.
REQ-006 Port spike_in, input, 3 bits: single-cycle output-neuron spikes; bit i is neuron i (0 = L-shape, 1 = T-shape, 2 = Cross).
REQ-007 Port aer_req, output, 1 bit: four-phase AER request.
REQ-008 Port aer_ack, input, 1 bit: four-phase AER acknowledge from the receiver.
REQ-009 Port aer_addr, output, 2 bits: neuron address of the current event.
REQ-010 Port aer_ts, output, TS_WIDTH bits: capture timestamp of the current event.
REQ-011 Port fifo_count, output, log2(FIFO_DEPTH)+1 bits: current FIFO occupancy.
REQ-012 Port drop_count, output, 8 bits: saturating count of lost spikes.
REQ-013 Port busy, output, 1 bit: set when any pending latch is set, the FIFO is non-empty, or the FSM is not IDLE.

Function
REQ-014 The timestamp counter SHALL increment by 1 each cycle while enable=1, hold while enable=0, and wrap from 2^TS_WIDTH-1 to 0.
REQ-015 Capture: with spike_in[i]=1 and enable=1 at an edge, pending[i] SHALL be set and ts_lat[i] SHALL load the current timestamp counter value from before that edge's increment.
REQ-016 Drop: a spike on a neuron whose pending bit is set and not granted in the same cycle SHALL be discarded, leaving pending and ts_lat unchanged, and drop_count SHALL increment and saturate at 255.
REQ-017 A spike arriving in the same cycle its neuron is granted SHALL re-set pending with the new timestamp and SHALL NOT count as a drop.
REQ-018 Spikes arriving while enable=0 SHALL be ignored and not counted; pending latches, the FIFO and the handshake SHALL keep draining.
REQ-019 Arbiter: in each cycle with any pending bit set and the FIFO not full, exactly one neuron SHALL be granted, chosen round-robin starting from the index after the last grant (reset pointer: neuron 0 has highest priority).
REQ-020 A grant SHALL push {i, ts_lat[i]} into the FIFO and clear pending[i] at the same edge.
REQ-021 When the FIFO is full there SHALL be no grant, and pending bits SHALL hold.
REQ-022 FIFO: synchronous, first-in first-out, with wrapping pointers; a simultaneous push and pop SHALL leave fifo_count unchanged.
REQ-023 A push while full SHALL never occur (guaranteed by REQ-021); a pop while empty SHALL never occur.
REQ-024 The transmit FSM SHALL have the states IDLE, REQ and ACK_LOW.
REQ-025 In IDLE with the FIFO non-empty and aer_ack=0, the FSM SHALL pop the head entry into aer_addr/aer_ts, set aer_req=1 and go to REQ, all at one edge.
REQ-026 In REQ, aer_req, aer_addr and aer_ts SHALL hold stable; on aer_ack=1 the FSM SHALL clear aer_req and go to ACK_LOW.
REQ-027 In ACK_LOW, on aer_ack=0 the FSM SHALL go to IDLE; aer_addr and aer_ts SHALL hold their last values.
REQ-028 In IDLE with aer_ack=1 (protocol violation), the FSM SHALL stay in IDLE and SHALL NOT pop.
REQ-029 Latency: with the FIFO empty, the FSM in IDLE and aer_ack=0, a spike sampled at edge k SHALL be pushed at edge k+1 and SHALL raise aer_req after edge k+2.
REQ-030 Event ordering SHALL be preserved from grant order to AER output; no event SHALL be duplicated.

Reset
REQ-031 On rst_n=0 the block SHALL asynchronously clear the timestamp counter, pending bits, ts_lat, the FIFO pointers, fifo_count, drop_count and the arbiter pointer, and SHALL force the FSM to IDLE.
REQ-032 During reset, aer_req, aer_addr, aer_ts and busy SHALL be 0.
REQ-033 Reset asserted mid-handshake SHALL drop aer_req immediately, and all queued events SHALL be lost.
REQ-034 After reset release, the first capture SHALL be able to occur at the first rising edge.

Verification
REQ-035 Single spike: enable=1, spike_in=3'b010 at edge 5, with the receiver acking 2 cycles after req -> aer_req rises after edge 7 with aer_addr=1 and aer_ts=5, one event total, drop_count=0.
REQ-036 Simultaneous spikes: spike_in=3'b111 in one cycle -> three events with addresses 0, 1, 2 in that order and identical aer_ts.
REQ-037 Backpressure: aer_ack held 0, and neuron 0 spiking every cycle for 20 cycles -> fifo_count saturates at 8, FIFO contents stay intact, and drop_count increments on each spike while pending[0] is blocked by the full FIFO.
REQ-038 Fairness: neurons 0 and 2 spiking every cycle while the FIFO has space -> granted addresses alternate 0, 2, 0, 2, with no starvation of neuron 2.
REQ-039 Wrap and enable: with TS_WIDTH=4, 20 enabled cycles followed by a spike -> aer_ts=4; with enable=0, spikes produce no events and the counter holds.
REQ-040 Reset in REQ state: rst_n pulsed low while aer_req=1 with 3 events queued -> aer_req=0 immediately, fifo_count=0, busy=0, and no event appears after release.
